// File: rtl/ctrl_pkg.sv
// Shared encodings for the RV64I multicycle controller: opcodes, FSM states,
// immediate formats, datapath mux codes and the decoded instruction class.
package ctrl_pkg;

    localparam logic [6:0] OPC_LOAD      = 7'b0000011;
    localparam logic [6:0] OPC_STORE     = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH    = 7'b1100011;
    localparam logic [6:0] OPC_JAL       = 7'b1101111;
    localparam logic [6:0] OPC_JALR      = 7'b1100111;
    localparam logic [6:0] OPC_OP_IMM    = 7'b0010011;
    localparam logic [6:0] OPC_OP_IMM_32 = 7'b0011011;
    localparam logic [6:0] OPC_OP        = 7'b0110011;
    localparam logic [6:0] OPC_OP_32     = 7'b0111011;
    localparam logic [6:0] OPC_LUI       = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC     = 7'b0010111;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    localparam logic [2:0] IMM_I = 3'd0;
    localparam logic [2:0] IMM_J = 3'd1;
    localparam logic [2:0] IMM_U = 3'd2;
    localparam logic [2:0] IMM_B = 3'd3;
    localparam logic [2:0] IMM_S = 3'd4;

    localparam logic [1:0] PC_SRC_PLUS4 = 2'd0;
    localparam logic [1:0] PC_SRC_IMM   = 2'd1;
    localparam logic [1:0] PC_SRC_JALR  = 2'd2;

    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC4 = 2'd2;

    localparam logic [1:0] ALU_A_RS1  = 2'd0;
    localparam logic [1:0] ALU_A_PC   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO = 2'd2;
    localparam logic       ALU_B_RS2  = 1'b0;
    localparam logic       ALU_B_IMM  = 1'b1;

    localparam logic [1:0] ALU_OP_ADD   = 2'd0;
    localparam logic [1:0] ALU_OP_FUNCT = 2'd1;
    localparam logic [1:0] ALU_OP_CMP   = 2'd2;

    localparam logic [3:0] CL_NONE    = 4'd0;
    localparam logic [3:0] CL_LOAD    = 4'd1;
    localparam logic [3:0] CL_STORE   = 4'd2;
    localparam logic [3:0] CL_BRANCH  = 4'd3;
    localparam logic [3:0] CL_JAL     = 4'd4;
    localparam logic [3:0] CL_JALR    = 4'd5;
    localparam logic [3:0] CL_ALU_IMM = 4'd6;
    localparam logic [3:0] CL_ALU_REG = 4'd7;
    localparam logic [3:0] CL_LUI     = 4'd8;
    localparam logic [3:0] CL_AUIPC   = 4'd9;

endpackage

// File: rtl/decod_opcode.sv
// Combinational opcode decoder: immediate format, instruction class and legality.
module decod_opcode
    import ctrl_pkg::*;
(
    input  logic [6:0] opcode_i,
    output logic [2:0] imm_fmt_o,
    output logic [3:0] cls_o,
    output logic       legal_o
);

    always_comb begin
        imm_fmt_o = IMM_I;
        cls_o     = CL_NONE;
        legal_o   = 1'b0;
        if (opcode_i[1:0] == 2'b11) begin
            legal_o = 1'b1;
            case (opcode_i)
                OPC_LOAD:                  cls_o = CL_LOAD;
                OPC_OP_IMM, OPC_OP_IMM_32: cls_o = CL_ALU_IMM;
                OPC_JALR:                  cls_o = CL_JALR;
                OPC_OP, OPC_OP_32:         cls_o = CL_ALU_REG;
                OPC_JAL: begin
                    imm_fmt_o = IMM_J;
                    cls_o     = CL_JAL;
                end
                OPC_LUI: begin
                    imm_fmt_o = IMM_U;
                    cls_o     = CL_LUI;
                end
                OPC_AUIPC: begin
                    imm_fmt_o = IMM_U;
                    cls_o     = CL_AUIPC;
                end
                OPC_BRANCH: begin
                    imm_fmt_o = IMM_B;
                    cls_o     = CL_BRANCH;
                end
                OPC_STORE: begin
                    imm_fmt_o = IMM_S;
                    cls_o     = CL_STORE;
                end
                default: legal_o = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/controle_multiciclo.sv
// Multicycle control FSM for the RV64I dataflow: sequences fetch through
// writeback and drives the datapath muxes, PC/IR/regfile strobes and memory handshake.
//
// state  | meaning
// FETCH  | request instruction at PC, load IR on mem_ready
// DECODE | latch opcode/class, select immediate format, trap if illegal
// EXEC   | ALU operation; branches and jumps finish here
// MEM    | data access at ALU address; stores finish here
// WB     | register write, PC+4
// TRAP   | frozen until reset (illegal opcode or memory timeout)
module controle_multiciclo
    import ctrl_pkg::*;
#(
    parameter int unsigned MEM_TIMEOUT = 255,
    parameter int unsigned CNT_W       = 8
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic [6:0] opcode_i,
    input  logic       mem_ready_i,
    input  logic       branch_taken_i,
    output logic       ir_load_o,
    output logic       pc_load_o,
    output logic [1:0] pc_src_o,
    output logic [2:0] select_imm_o,
    output logic [1:0] alu_src_a_o,
    output logic       alu_src_b_o,
    output logic [1:0] alu_op_o,
    output logic       reg_we_o,
    output logic [1:0] wb_sel_o,
    output logic       mem_req_o,
    output logic       mem_we_o,
    output logic       addr_sel_o,
    output logic       illegal_o,
    output logic       bus_err_o
);

    localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(MEM_TIMEOUT);

    logic [2:0]       state_q, state_d;
    logic [6:0]       op_q, op_d;
    logic [3:0]       cls_q, cls_d;
    logic [2:0]       sel_imm_q, sel_imm_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
    logic             illegal_q, illegal_d;
    logic             bus_err_q, bus_err_d;

    logic [2:0] dec_imm;
    logic [3:0] dec_cls;
    logic       dec_legal;
    logic       ir_load, pc_load, reg_we, mem_req, mem_we;

    decod_opcode u_decod (
        .opcode_i  (opcode_i),
        .imm_fmt_o (dec_imm),
        .cls_o     (dec_cls),
        .legal_o   (dec_legal)
    );

    assign cnt_inc = cnt_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        cls_d     = cls_q;
        sel_imm_d = sel_imm_q;
        cnt_d     = '0;
        illegal_d = illegal_q;
        bus_err_d = bus_err_q;
        ir_load   = 1'b0;
        pc_load   = 1'b0;
        pc_src_o  = PC_SRC_PLUS4;
        reg_we    = 1'b0;
        wb_sel_o  = WB_ALU;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        addr_sel_o = 1'b0;
        case (state_q)
            ST_FETCH: begin
                mem_req = 1'b1;
                if (mem_ready_i) begin
                    ir_load = 1'b1;
                    state_d = ST_DECODE;
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_DECODE: begin
                op_d      = opcode_i;
                cls_d     = dec_cls;
                sel_imm_d = dec_imm;
                if (dec_legal) begin
                    state_d = ST_EXEC;
                end else begin
                    illegal_d = 1'b1;
                    state_d   = ST_TRAP;
                end
            end
            ST_EXEC: begin
                case (cls_q)
                    CL_BRANCH: begin
                        pc_load  = 1'b1;
                        pc_src_o = branch_taken_i ? PC_SRC_IMM : PC_SRC_PLUS4;
                        state_d  = ST_FETCH;
                    end
                    CL_JAL, CL_JALR: begin
                        reg_we   = 1'b1;
                        wb_sel_o = WB_PC4;
                        pc_load  = 1'b1;
                        pc_src_o = (cls_q == CL_JAL) ? PC_SRC_IMM : PC_SRC_JALR;
                        state_d  = ST_FETCH;
                    end
                    CL_LOAD, CL_STORE:                        state_d = ST_MEM;
                    CL_ALU_IMM, CL_ALU_REG, CL_LUI, CL_AUIPC: state_d = ST_WB;
                    default:                                  state_d = ST_FETCH;
                endcase
            end
            ST_MEM: begin
                mem_req    = 1'b1;
                addr_sel_o = 1'b1;
                mem_we     = (op_q == OPC_STORE);
                if (mem_ready_i) begin
                    if (op_q == OPC_STORE) begin
                        pc_load = 1'b1;
                        state_d = ST_FETCH;
                    end else begin
                        state_d = ST_WB;
                    end
                end else if (cnt_inc == TIMEOUT_CNT) begin
                    bus_err_d = 1'b1;
                    state_d   = ST_TRAP;
                end else begin
                    cnt_d = cnt_inc;
                end
            end
            ST_WB: begin
                reg_we   = 1'b1;
                wb_sel_o = (op_q == OPC_LOAD) ? WB_MEM : WB_ALU;
                pc_load  = 1'b1;
                state_d  = ST_FETCH;
            end
            ST_TRAP: state_d = ST_TRAP;
            default: state_d = ST_FETCH;
        endcase
    end

    // Operand muxes are a function of the instruction class only, so they hold through MEM and WB.
    always_comb begin
        alu_src_a_o = ALU_A_RS1;
        alu_src_b_o = ALU_B_RS2;
        alu_op_o    = ALU_OP_ADD;
        if (state_q == ST_EXEC || state_q == ST_MEM || state_q == ST_WB) begin
            case (cls_q)
                CL_BRANCH:                  alu_op_o = ALU_OP_CMP;
                CL_JALR, CL_LOAD, CL_STORE: alu_src_b_o = ALU_B_IMM;
                CL_ALU_IMM: begin
                    alu_src_b_o = ALU_B_IMM;
                    alu_op_o    = ALU_OP_FUNCT;
                end
                CL_ALU_REG:                 alu_op_o = ALU_OP_FUNCT;
                CL_LUI: begin
                    alu_src_a_o = ALU_A_ZERO;
                    alu_src_b_o = ALU_B_IMM;
                end
                CL_AUIPC: begin
                    alu_src_a_o = ALU_A_PC;
                    alu_src_b_o = ALU_B_IMM;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q   <= ST_FETCH;
            op_q      <= '0;
            cls_q     <= CL_NONE;
            sel_imm_q <= IMM_I;
            cnt_q     <= '0;
            illegal_q <= 1'b0;
            bus_err_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            cls_q     <= cls_d;
            sel_imm_q <= sel_imm_d;
            cnt_q     <= cnt_d;
            illegal_q <= illegal_d;
            bus_err_q <= bus_err_d;
        end
    end

    // Strobes are masked during reset so an in-flight request is dropped immediately.
    assign ir_load_o    = ir_load & ~reset_i;
    assign pc_load_o    = pc_load & ~reset_i;
    assign reg_we_o     = reg_we  & ~reset_i;
    assign mem_req_o    = mem_req & ~reset_i;
    assign mem_we_o     = mem_we  & ~reset_i;
    assign select_imm_o = sel_imm_q;
    assign illegal_o    = illegal_q;
    assign bus_err_o    = bus_err_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// Directed bench for controle_multiciclo: per-instruction cycle sequences,
// memory wait/timeout, illegal trap and reset abandonment.
module tb_controle_multiciclo;

    logic       clk = 1'b0;
    logic       reset_i, mem_ready_i, branch_taken_i;
    logic [6:0] opcode_i;
    logic       ir_load_o, pc_load_o, alu_src_b_o, reg_we_o;
    logic       mem_req_o, mem_we_o, addr_sel_o, illegal_o, bus_err_o;
    logic [1:0] pc_src_o, alu_src_a_o, alu_op_o, wb_sel_o;
    logic [2:0] select_imm_o;
    logic [4:0] stb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    // {ir_load, pc_load, reg_we, mem_req, mem_we}
    assign stb = {ir_load_o, pc_load_o, reg_we_o, mem_req_o, mem_we_o};

    controle_multiciclo #(.MEM_TIMEOUT(255), .CNT_W(8)) dut (
        .clk_i(clk), .reset_i(reset_i), .opcode_i(opcode_i),
        .mem_ready_i(mem_ready_i), .branch_taken_i(branch_taken_i),
        .ir_load_o(ir_load_o), .pc_load_o(pc_load_o), .pc_src_o(pc_src_o),
        .select_imm_o(select_imm_o), .alu_src_a_o(alu_src_a_o),
        .alu_src_b_o(alu_src_b_o), .alu_op_o(alu_op_o), .reg_we_o(reg_we_o),
        .wb_sel_o(wb_sel_o), .mem_req_o(mem_req_o), .mem_we_o(mem_we_o),
        .addr_sel_o(addr_sel_o), .illegal_o(illegal_o), .bus_err_o(bus_err_o)
    );

    task automatic nxt();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_i = 1'b1; mem_ready_i = 1'b1; branch_taken_i = 1'b0; opcode_i = 7'h13;
        nxt(); nxt(); #1;
        checks++; if (stb !== 5'b00000) begin errors++; $display("FAIL reset_strobes got %b exp 00000", stb); end
        checks++; if ({select_imm_o, illegal_o, bus_err_o} !== 5'b00000) begin errors++;
            $display("FAIL reset_regs sel=%0d ill=%b berr=%b exp 0 0 0", select_imm_o, illegal_o, bus_err_o); end
        nxt();
        reset_i = 1'b0;
    endtask

    task automatic test_addi();
        opcode_i = 7'h13; mem_ready_i = 1'b1; #1;
        checks++; if ({stb, addr_sel_o} !== 6'b100100) begin errors++; $display("FAIL addi_fetch stb=%b addr=%b exp 10010 0", stb, addr_sel_o); end
        nxt(); #1;
        checks++; if (stb !== 5'b00000) begin errors++; $display("FAIL addi_decode stb=%b exp 00000", stb); end
        nxt(); #1;
        checks++; if ({select_imm_o, alu_src_b_o, alu_op_o, stb} !== {3'd0, 1'b1, 2'd1, 5'b00000}) begin errors++;
            $display("FAIL addi_exec sel=%0d b=%b op=%0d stb=%b exp 0 1 1 00000", select_imm_o, alu_src_b_o, alu_op_o, stb); end
        nxt(); #1;
        checks++; if ({stb, wb_sel_o, pc_src_o} !== {5'b01100, 2'd0, 2'd0}) begin errors++;
            $display("FAIL addi_wb stb=%b wb=%0d pcs=%0d exp 01100 0 0", stb, wb_sel_o, pc_src_o); end
        nxt(); #1;
        checks++; if (stb !== 5'b10010) begin errors++; $display("FAIL addi_cpi4 stb=%b exp 10010", stb); end
    endtask

    task automatic test_load_store();
        logic is_st;
        for (int k = 0; k < 2; k++) begin
            is_st = (k == 1);
            opcode_i = is_st ? 7'h23 : 7'h03; mem_ready_i = 1'b1; #1;
            checks++; if (stb !== 5'b10010) begin errors++; $display("FAIL ls%0d_fetch stb=%b exp 10010", k, stb); end
            nxt(); mem_ready_i = 1'b0; #1;
            nxt(); #1;
            checks++; if ({select_imm_o, alu_src_a_o, alu_src_b_o, alu_op_o, stb} !== {(is_st ? 3'd4 : 3'd0), 2'd0, 1'b1, 2'd0, 5'b00000}) begin errors++;
                $display("FAIL ls%0d_exec sel=%0d a=%0d b=%b op=%0d stb=%b", k, select_imm_o, alu_src_a_o, alu_src_b_o, alu_op_o, stb); end
            for (int i = 0; i < 4; i++) begin
                nxt(); mem_ready_i = (i == 3); #1;
                checks++;
                if ({mem_req_o, mem_we_o, addr_sel_o, pc_load_o, reg_we_o, ir_load_o, alu_src_b_o} !==
                    {1'b1, is_st, 1'b1, (is_st && i == 3), 1'b0, 1'b0, 1'b1}) begin errors++;
                    $display("FAIL ls%0d_mem%0d req=%b we=%b addr=%b pcl=%b rwe=%b irl=%b b=%b", k, i,
                             mem_req_o, mem_we_o, addr_sel_o, pc_load_o, reg_we_o, ir_load_o, alu_src_b_o); end
            end
            nxt(); mem_ready_i = 1'b1; #1;
            if (!is_st) begin
                checks++; if ({stb, wb_sel_o} !== {5'b01100, 2'd1}) begin errors++; $display("FAIL lw_wb stb=%b wb=%0d exp 01100 1", stb, wb_sel_o); end
                nxt(); #1;
            end
            checks++; if (stb !== 5'b10010) begin errors++; $display("FAIL ls%0d_refetch stb=%b exp 10010", k, stb); end
        end
    endtask

    task automatic test_branch();
        logic taken;
        for (int k = 0; k < 2; k++) begin
            taken = (k == 0);
            opcode_i = 7'h63; mem_ready_i = 1'b1; branch_taken_i = 1'b0; #1;
            nxt(); #1;
            nxt(); branch_taken_i = taken; #1;
            checks++; if ({select_imm_o, stb, pc_src_o, alu_op_o, alu_src_b_o} !== {3'd3, 5'b01000, (taken ? 2'd1 : 2'd0), 2'd2, 1'b0}) begin errors++;
                $display("FAIL beq%0d_exec sel=%0d stb=%b pcs=%0d op=%0d b=%b", k, select_imm_o, stb, pc_src_o, alu_op_o, alu_src_b_o); end
            nxt(); branch_taken_i = 1'b0; #1;
            checks++; if (stb !== 5'b10010) begin errors++; $display("FAIL beq%0d_cpi3 stb=%b exp 10010", k, stb); end
        end
    endtask

    typedef struct packed {
        logic [6:0] opc;
        logic [2:0] sel;
        logic [4:0] stb_e;
        logic [1:0] wb_e;
        logic [1:0] pcs_e;
        logic [1:0] alua_e;
        logic       has_wb;
    } jvec_t;

    task automatic test_jump_upper();
        jvec_t tbl [4];
        tbl[0] = '{7'h6F, 3'd1, 5'b01100, 2'd2, 2'd1, 2'd0, 1'b0};
        tbl[1] = '{7'h67, 3'd0, 5'b01100, 2'd2, 2'd2, 2'd0, 1'b0};
        tbl[2] = '{7'h37, 3'd2, 5'b00000, 2'd0, 2'd0, 2'd2, 1'b1};
        tbl[3] = '{7'h17, 3'd2, 5'b00000, 2'd0, 2'd0, 2'd1, 1'b1};
        for (int k = 0; k < 4; k++) begin
            opcode_i = tbl[k].opc; mem_ready_i = 1'b1; #1;
            nxt(); #1;
            nxt(); #1;
            checks++; if ({select_imm_o, stb, wb_sel_o, pc_src_o, alu_src_a_o} !== {tbl[k].sel, tbl[k].stb_e, tbl[k].wb_e, tbl[k].pcs_e, tbl[k].alua_e}) begin errors++;
                $display("FAIL ju%0d_exec sel=%0d stb=%b wb=%0d pcs=%0d a=%0d", k, select_imm_o, stb, wb_sel_o, pc_src_o, alu_src_a_o); end
            if (tbl[k].has_wb) begin
                nxt(); #1;
                checks++; if ({stb, wb_sel_o, alu_src_a_o, alu_src_b_o} !== {5'b01100, 2'd0, tbl[k].alua_e, 1'b1}) begin errors++;
                    $display("FAIL ju%0d_wb stb=%b wb=%0d a=%0d b=%b", k, stb, wb_sel_o, alu_src_a_o, alu_src_b_o); end
            end
            nxt(); #1;
            checks++; if (stb !== 5'b10010) begin errors++; $display("FAIL ju%0d_refetch stb=%b exp 10010", k, stb); end
        end
    endtask

    task automatic test_illegal();
        opcode_i = 7'h7F; mem_ready_i = 1'b1; #1;
        nxt(); #1;
        checks++; if ({stb, illegal_o} !== 6'b000000) begin errors++; $display("FAIL ill_decode stb=%b ill=%b exp 00000 0", stb, illegal_o); end
        nxt(); #1;
        checks++; if ({stb, illegal_o} !== 6'b000001) begin errors++; $display("FAIL ill_trap stb=%b ill=%b exp 00000 1", stb, illegal_o); end
        for (int i = 0; i < 20; i++) begin
            nxt(); mem_ready_i = i[0]; branch_taken_i = ~i[0]; #1;
            checks++; if ({stb, illegal_o, bus_err_o} !== 7'b0000010) begin errors++;
                $display("FAIL ill_hold%0d stb=%b ill=%b berr=%b", i, stb, illegal_o, bus_err_o); end
        end
        reset_i = 1'b1; #1;
        nxt(); reset_i = 1'b0; mem_ready_i = 1'b1; branch_taken_i = 1'b0; opcode_i = 7'h13; #1;
        checks++; if ({stb, illegal_o} !== 6'b100100) begin errors++; $display("FAIL ill_reset stb=%b ill=%b exp 10010 0", stb, illegal_o); end
    endtask

    task automatic test_bus_timeout();
        reset_i = 1'b1; #1;
        nxt(); reset_i = 1'b0; mem_ready_i = 1'b0; #1;
        for (int i = 0; i < 254; i++) nxt();
        #1;
        checks++; if ({mem_req_o, bus_err_o} !== 2'b10) begin errors++; $display("FAIL tmo_254 req=%b berr=%b exp 1 0", mem_req_o, bus_err_o); end
        nxt(); #1;
        checks++; if ({stb, bus_err_o, illegal_o} !== 7'b0000010) begin errors++;
            $display("FAIL tmo_255 stb=%b berr=%b ill=%b exp 00000 1 0", stb, bus_err_o, illegal_o); end
        nxt(); mem_ready_i = 1'b1; #1;
        checks++; if ({stb, bus_err_o} !== 6'b000001) begin errors++; $display("FAIL tmo_sticky stb=%b berr=%b", stb, bus_err_o); end
    endtask

    task automatic test_reset_in_mem();
        reset_i = 1'b1; mem_ready_i = 1'b1; opcode_i = 7'h03; #1;
        nxt(); reset_i = 1'b0; #1;
        checks++; if ({stb, bus_err_o} !== 6'b100100) begin errors++; $display("FAIL rm_fetch stb=%b berr=%b exp 10010 0", stb, bus_err_o); end
        nxt(); nxt(); nxt(); mem_ready_i = 1'b0; #1;
        checks++; if ({mem_req_o, addr_sel_o} !== 2'b11) begin errors++; $display("FAIL rm_mem req=%b addr=%b exp 1 1", mem_req_o, addr_sel_o); end
        reset_i = 1'b1; #1;
        checks++; if (stb !== 5'b00000) begin errors++; $display("FAIL rm_drop stb=%b exp 00000", stb); end
        nxt(); reset_i = 1'b0; #1;
        checks++; if ({stb, addr_sel_o} !== 6'b000100) begin errors++; $display("FAIL rm_refetch stb=%b addr=%b exp 00010 0", stb, addr_sel_o); end
    endtask

    initial begin
        test_reset();
        test_addi();
        test_load_store();
        test_branch();
        test_jump_upper();
        test_illegal();
        test_bus_timeout();
        test_reset_in_mem();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog expired after 200000 time units");
        $fatal(1);
    end

endmodule

// File: doc/controle_multiciclo.md
Name: controle_multiciclo

Overview:
- Multicycle control FSM for the RV64I dataflow.
- Sequences fetch/decode/execute/memory/writeback and drives the immediate-converter format select (I=0, J=1, U=2, B=3, S=4).
- Also drives the ALU operand muxes, PC update, register-file write and a shared instruction/data memory request/ready handshake.
- Sits beside the datapath and consumes only opcode, branch flag and memory ready.

Parameters:
- MEM_TIMEOUT, 255: maximum cycles to wait for mem_ready in FETCH or MEM before trapping.
- CNT_W, 8: width of the wait counter; must satisfy 2^CNT_W > MEM_TIMEOUT.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- opcode  in  7  instr[6:0] from the instruction register.
- mem_ready  in  1  memory completes the current request this cycle.
- branch_taken  in  1  datapath comparator result for the current branch (funct3 already applied).
- ir_load  out  1  load the instruction register from memory read data.
- pc_load  out  1  update PC this cycle.
- pc_src  out  2  0=PC+4, 1=PC+imm, 2=ALU result with bit0 cleared (JALR).
- select_imm  out  3  immediate format to the converter.
- alu_src_a  out  2  0=rs1, 1=PC, 2=zero.
- alu_src_b  out  1  0=rs2, 1=imm.
- alu_op  out  2  0=add, 1=per funct3/funct7, 2=compare.
- reg_we  out  1  register-file write enable.
- wb_sel  out  2  0=ALU, 1=memory data, 2=PC+4.
- mem_req  out  1  memory request valid.
- mem_we  out  1  request is a store (meaningful only with mem_req).
- addr_sel  out  1  memory address: 0=PC, 1=ALU result.
- illegal  out  1  sticky: unknown opcode.
- bus_err  out  1  sticky: memory timeout.

Behaviour:
- States: FETCH, DECODE, EXEC, MEM, WB, TRAP.
- Reset: state=FETCH, op_q=0, select_imm=0, wait counter=0, illegal=0, bus_err=0.
  - All strobes (ir_load, pc_load, reg_we, mem_req, mem_we) are 0 in the reset cycle.
  - A reset asserted mid-instruction abandons it at the next edge; a pending request is dropped without completion.
- Strobes are combinational from state, op_q, mem_ready and branch_taken; select_imm and op_q are registered.
- FETCH:
  - mem_req=1, mem_we=0, addr_sel=0.
  - If mem_ready: ir_load=1, go to DECODE.
  - Otherwise increment the counter; when it reaches MEM_TIMEOUT, set bus_err and go to TRAP.
  - The counter clears on every state change.
- DECODE:
  - Latch op_q=opcode.
  - Set select_imm: LOAD/OP-IMM/OP-IMM-32/JALR -> I; JAL -> J; LUI/AUIPC -> U; BRANCH -> B; STORE -> S; OP/OP-32 -> I (don't-care).
  - Unknown opcode or opcode[1:0]!=2'b11: set illegal, go to TRAP. Otherwise go to EXEC.
- EXEC:
  - BRANCH: alu_op=2, alu_src_b=0, pc_load=1, pc_src = branch_taken?1:0, go to FETCH.
  - JAL: reg_we=1, wb_sel=2, pc_load=1, pc_src=1, go to FETCH.
  - JALR: alu_src_a=0, alu_src_b=1, alu_op=0, reg_we=1, wb_sel=2, pc_load=1, pc_src=2, go to FETCH.
  - LOAD/STORE: alu_src_a=0, alu_src_b=1, alu_op=0, go to MEM.
  - OP-IMM(-32): alu_src_b=1, alu_op=1. OP(-32): alu_src_b=0, alu_op=1.
  - LUI: alu_src_a=2, alu_src_b=1. AUIPC: alu_src_a=1, alu_src_b=1.
  - All ALU classes go to WB.
- MEM:
  - mem_req=1, addr_sel=1, mem_we=(op_q==STORE). The ALU operand muxes hold their EXEC values.
  - On mem_ready: STORE -> pc_load=1, pc_src=0, go to FETCH; LOAD -> go to WB.
  - Timeout behaves as in FETCH.
- WB: reg_we=1, wb_sel = LOAD?1:0, pc_load=1, pc_src=0, go to FETCH. The operand muxes hold their EXEC values.
- TRAP: all strobes 0; stay until reset. Both illegal and bus_err may be set.
- CPI with zero-wait memory (mem_ready high in the request cycle): ALU 4, load 5, store 4, branch/JAL/JALR 3.
- mem_req is never asserted outside FETCH and MEM.
- pc_load and ir_load are never high in the same cycle.
- reg_we is never high in FETCH, DECODE or MEM.

Decomposition:
- Package ctrl_pkg holds:
  - opcode constants;
  - state encoding (3-bit);
  - IMM_I..IMM_S codes matching the converter;
  - PC_SRC_*, WB_*, ALU_A_*, ALU_OP_* codes.
- Sub-module decod_opcode (combinational): opcode -> {imm_fmt, class, legal}; used in DECODE.

Test Plan:
- addi (0x00500093), mem_ready always 1:
  - select_imm=0 from the DECODE edge;
  - EXEC alu_src_b=1, alu_op=1;
  - WB reg_we=1, wb_sel=0, pc_load=1, pc_src=0;
  - 4 cycles total.
- lw then sw, mem_ready delayed 3 cycles in MEM:
  - MEM holds mem_req=1, addr_sel=1 for 4 cycles;
  - mem_we=0 for the load, 1 for the store (select_imm=4);
  - load reaches WB with wb_sel=1; store returns to FETCH with no reg_we.
- beq with branch_taken=1, then 0:
  - select_imm=3;
  - EXEC pc_load=1 with pc_src=1, then pc_src=0;
  - 3 cycles each.
- jal, jalr, lui, auipc:
  - select_imm 1, 0, 2, 2;
  - JAL/JALR: wb_sel=2 with pc_src 1/2;
  - LUI: alu_src_a=2; AUIPC: alu_src_a=1.
- opcode 0x7F:
  - illegal=1 and TRAP after DECODE;
  - all strobes 0 for 20 further cycles;
  - reset clears illegal and returns to FETCH.
- mem_ready held 0 in FETCH: bus_err=1 after 255 wait cycles. Separately, reset asserted during MEM: mem_req=0 and FETCH on the next cycle.
